// File: rtl/regfile_pkg.sv
// Shared register-file constants: default geometry and the hard-wired zero register.
// The hazard unit and decode stage import the same values so all three agree.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  localparam logic [AW_DEF-1:0] REG_ZERO = {AW_DEF{1'b0}};

  // True when addr names a real, writable register (not x0, not beyond the file).
  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned nregs);
    return (addr != 32'd0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on alloc, cleared on write.
// An alloc and a write to the same register in one cycle leave it busy, because the
// newly issued producer supersedes the one completing now.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS),
  parameter int NWP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWP-1:0]    we,
  input  logic [NWP*AW-1:0] wa,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Next busy vector: completing writes clear first, then the alloc sets on top.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWP; j++) begin
      if (we[j] && addr_valid(32'(wa[j*AW +: AW]), NREGS)) begin
        w_busy_nxt[wa[j*AW +: AW]] = 1'b0;
      end else begin
        w_busy_nxt = w_busy_nxt;
      end
    end
    if (alloc_en && addr_valid(32'(alloc_addr), NREGS)) begin
      w_busy_nxt[alloc_addr] = 1'b1;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy register; asynchronous reset drops every outstanding producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {NREGS{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read bypass
// and a pending-write scoreboard. Register 0 reads zero and is never written or busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = $clog2(NREGS),
  parameter int NRP    = 2,
  parameter int NWP    = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  output logic [NRP-1:0]      rd_busy,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic [NWP*XLEN-1:0] wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NWP   (NWP)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .wa         (wa),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy       (w_busy)
  );

  assign busy = w_busy;

  // Storage update; ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= {XLEN{1'b0}};
      end
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (we[j] && addr_valid(32'(wa[j*AW +: AW]), NREGS)) begin
          r_regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports with bypass, zero-register and reset gating.
  always_comb begin
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_data;
    logic            w_hit;
    rd      = {(NRP*XLEN){1'b0}};
    rd_busy = {NRP{1'b0}};
    for (int i = 0; i < NRP; i++) begin
      w_ra   = ra[i*AW +: AW];
      w_data = r_regs[w_ra];
      w_hit  = 1'b0;
      for (int j = 0; j < NWP; j++) begin
        if ((BYPASS != 0) && we[j] && (wa[j*AW +: AW] == w_ra)) begin
          w_hit  = 1'b1;
          w_data = wd[j*XLEN +: XLEN];
        end else begin
          w_hit  = w_hit;
        end
      end
      if (rst_n && addr_valid(32'(w_ra), NREGS)) begin
        rd[i*XLEN +: XLEN] = w_data;
        rd_busy[i]         = w_busy[w_ra] & ~w_hit;
      end else begin
        rd[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[i]         = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array/bit-vector reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRP   = 2;
  localparam int NWP   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRP*AW-1:0]   ra;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   wa;
  logic [NWP*XLEN-1:0] wd;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;

  logic [NRP*XLEN-1:0] rd_b, rd_n;
  logic [NRP-1:0]      rdb_b, rdb_n;
  logic [NREGS-1:0]    busy_b, busy_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rd_busy(rdb_n),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_n)
  );

  always #5 clk = ~clk;

  // Expected read data: last matching writer among this cycle's writes, else stored value.
  function automatic logic [XLEN-1:0] exp_rd(int p, bit byp);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] q[$];
    a = ra[p*AW +: AW];
    if (!rst_n || a == 5'd0) return 32'd0;
    if (byp) begin
      for (int j = 0; j < NWP; j++)
        if (we[j] && wa[j*AW +: AW] == a) q.push_back(wd[j*XLEN +: XLEN]);
    end
    if (q.size() > 0) return q[$];
    return m_regs[a];
  endfunction

  function automatic logic exp_rdb(int p, bit byp);
    logic [AW-1:0] a;
    bit written;
    a = ra[p*AW +: AW];
    written = 1'b0;
    if (!rst_n || a == 5'd0) return 1'b0;
    for (int j = 0; j < NWP; j++)
      if (we[j] && wa[j*AW +: AW] == a) written = 1'b1;
    return m_busy[a] && !(byp && written);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NREGS; k++) m_regs[k] = 32'd0;
    m_busy = 32'd0;
  endtask

  // Advance one clock and apply the architectural update rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      for (int j = 0; j < NWP; j++) begin
        if (we[j] && wa[j*AW +: AW] != 5'd0) begin
          m_regs[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
          m_busy[wa[j*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic drive_idle();
    we = 2'b00; wa = 10'd0; wd = 64'd0; alloc_en = 1'b0; alloc_addr = 5'd0; ra = 10'd0;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF};
    alloc_en = 1'b1; alloc_addr = 5'd5; ra = {5'd5, 5'd5};
    #1;
    n_checks++; if (rd_b !== 64'd0) begin n_fail++; $display("FAIL reset_rd_byp: got %h expected 0", rd_b); end
    n_checks++; if (rd_n !== 64'd0) begin n_fail++; $display("FAIL reset_rd_nob: got %h expected 0", rd_n); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy_b !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy_b); end
    n_checks++; if (rdb_b !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy: got %b expected 00", rdb_b); end
    n_checks++; if (rd_b[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_rd_held: got %h expected 0", rd_b[31:0]); end
    rst_n = 1'b1;
    we = 2'b00; alloc_en = 1'b0;
    #1;
    n_checks++; if (rd_b[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_release_rd: got %h expected 0", rd_b[31:0]); end
    step();
    n_checks++; if (rd_n[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_after_rd: got %h expected 0", rd_n[31:0]); end
  endtask

  task automatic test_basic_nobypass();
    drive_idle();
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h12345678}; ra = {5'd0, 5'd3};
    #1;
    n_checks++; if (rd_n[31:0] !== exp_rd(0, 1'b0)) begin n_fail++; $display("FAIL basic_old_value: got %h expected %h", rd_n[31:0], exp_rd(0, 1'b0)); end
    step();
    we = 2'b00;
    #1;
    n_checks++; if (rd_n[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL basic_new_value: got %h expected 12345678", rd_n[31:0]); end
  endtask

  task automatic test_bypass();
    drive_idle();
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'hA5A5A5A5}; ra = {5'd0, 5'd7};
    #1;
    n_checks++; if (rd_b[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected a5a5a5a5", rd_b[31:0]); end
    n_checks++; if (rd_n[31:0] !== 32'd0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h expected 0", rd_n[31:0]); end
    step();
    we = 2'b00;
    #1;
    n_checks++; if (rd_b[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_stored: got %h expected a5a5a5a5", rd_b[31:0]); end
    n_checks++; if (rd_n[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL nobypass_stored: got %h expected a5a5a5a5", rd_n[31:0]); end
  endtask

  task automatic test_reg0();
    drive_idle();
    we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'hFFFFFFFF, 32'hFFFFFFFF};
    alloc_en = 1'b1; alloc_addr = 5'd0; ra = {5'd0, 5'd0};
    #1;
    n_checks++; if (rd_b !== 64'd0) begin n_fail++; $display("FAIL reg0_bypass_rd: got %h expected 0", rd_b); end
    n_checks++; if (rdb_b !== 2'b00) begin n_fail++; $display("FAIL reg0_rd_busy: got %b expected 00", rdb_b); end
    step();
    drive_idle();
    #1;
    n_checks++; if (busy_b[0] !== 1'b0) begin n_fail++; $display("FAIL reg0_busy: got %b expected 0", busy_b[0]); end
    n_checks++; if (rd_n !== 64'd0) begin n_fail++; $display("FAIL reg0_stored: got %h expected 0", rd_n); end
  endtask

  task automatic test_collision();
    drive_idle();
    we = 2'b11; wa = {5'd9, 5'd9}; wd = {32'd2, 32'd1}; ra = {5'd0, 5'd9};
    #1;
    n_checks++; if (rd_b[31:0] !== 32'd2) begin n_fail++; $display("FAIL collision_bypass: got %h expected 2", rd_b[31:0]); end
    step();
    drive_idle();
    ra = {5'd9, 5'd9};
    #1;
    n_checks++; if (rd_b[63:32] !== 32'd2) begin n_fail++; $display("FAIL collision_store_byp: got %h expected 2", rd_b[63:32]); end
    n_checks++; if (rd_n[31:0] !== 32'd2) begin n_fail++; $display("FAIL collision_store_nob: got %h expected 2", rd_n[31:0]); end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    step();
    drive_idle();
    ra = {5'd0, 5'd4};
    #1;
    n_checks++; if (busy_b[4] !== 1'b1) begin n_fail++; $display("FAIL sb_alloc: got %b expected 1", busy_b[4]); end
    n_checks++; if (rdb_b[0] !== 1'b1) begin n_fail++; $display("FAIL sb_rd_busy_pending: got %b expected 1", rdb_b[0]); end
    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'h0000BEEF};
    #1;
    n_checks++; if (rdb_b[0] !== 1'b0) begin n_fail++; $display("FAIL sb_rd_busy_bypass: got %b expected 0", rdb_b[0]); end
    n_checks++; if (rdb_n[0] !== 1'b1) begin n_fail++; $display("FAIL sb_rd_busy_nobypass: got %b expected 1", rdb_n[0]); end
    step();
    drive_idle();
    #1;
    n_checks++; if (busy_b[4] !== 1'b0) begin n_fail++; $display("FAIL sb_clear: got %b expected 0", busy_b[4]); end
    alloc_en = 1'b1; alloc_addr = 5'd4;
    we = 2'b10; wa = {5'd4, 5'd0}; wd = {32'h00001111, 32'd0};
    step();
    drive_idle();
    #1;
    n_checks++; if (busy_b[4] !== 1'b1) begin n_fail++; $display("FAIL sb_alloc_wins: got %b expected 1", busy_b[4]); end
    n_checks++; if (busy_n[4] !== 1'b1) begin n_fail++; $display("FAIL sb_alloc_wins_nob: got %b expected 1", busy_n[4]); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_b !== 32'd0) begin n_fail++; $display("FAIL sb_async_reset: got %h expected 0", busy_b); end
    n_checks++; if (busy_n !== 32'd0) begin n_fail++; $display("FAIL sb_async_reset_nob: got %h expected 0", busy_n); end
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    for (int c = 0; c < 400; c++) begin
      we = 2'($urandom_range(0, 3));
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      wa = {a1, a0};
      wd = {$urandom, $urandom};
      alloc_en = 1'($urandom_range(0, 1));
      alloc_addr = 5'($urandom_range(0, 7));
      ra[4:0] = ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom_range(0, 31));
      ra[9:5] = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NRP; p++) begin
        n_checks++; if (rd_b[p*XLEN +: XLEN] !== exp_rd(p, 1'b1)) begin n_fail++; $display("FAIL rand_rd_byp c=%0d p=%0d: got %h expected %h", c, p, rd_b[p*XLEN +: XLEN], exp_rd(p, 1'b1)); end
        n_checks++; if (rd_n[p*XLEN +: XLEN] !== exp_rd(p, 1'b0)) begin n_fail++; $display("FAIL rand_rd_nob c=%0d p=%0d: got %h expected %h", c, p, rd_n[p*XLEN +: XLEN], exp_rd(p, 1'b0)); end
        n_checks++; if (rdb_b[p] !== exp_rdb(p, 1'b1)) begin n_fail++; $display("FAIL rand_rdbusy_byp c=%0d p=%0d: got %b expected %b", c, p, rdb_b[p], exp_rdb(p, 1'b1)); end
        n_checks++; if (rdb_n[p] !== exp_rdb(p, 1'b0)) begin n_fail++; $display("FAIL rand_rdbusy_nob c=%0d p=%0d: got %b expected %b", c, p, rdb_n[p], exp_rdb(p, 1'b0)); end
      end
      n_checks++; if (busy_b !== m_busy) begin n_fail++; $display("FAIL rand_busy_byp c=%0d: got %h expected %h", c, busy_b, m_busy); end
      n_checks++; if (busy_n !== m_busy) begin n_fail++; $display("FAIL rand_busy_nob c=%0d: got %h expected %h", c, busy_n, m_busy); end
      step();
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic_nobypass();
    test_bypass();
    test_reg0();
    test_collision();
    test_scoreboard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined core. It replaces the fixed 2R/1W file with configurable width, depth, read-port count and write-port count. It adds optional write-to-read bypass and a per-register pending-write scoreboard that the hazard unit uses for issue stalls. Register 0 reads as zero, is never written and is never pending.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), address width (derived; do not override)
NRP, 2, number of read ports
NWP, 1, number of write ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored state only

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ra  in  NRP*AW  read addresses; port i is ra[i*AW +: AW]
rd  out  NRP*XLEN  read data, combinational
rd_busy  out  NRP  read register still has an outstanding producer after this cycle's writes
we  in  NWP  write enables
wa  in  NWP*AW  write addresses
wd  in  NWP*XLEN  write data
alloc_en  in  1  mark alloc_addr as pending (instruction issued with destination)
alloc_addr  in  AW  destination being allocated
busy  out  NREGS  registered scoreboard vector; bit 0 constant 0

Behaviour:
- Reset is asynchronous and active-low: while rst_n=0, all registers clear to 0 and busy clears to 0.
- During reset, rd=0 and rd_busy=0 on all ports; bypass is gated off; writes and allocs are ignored.
- Write at posedge clk: for each port j with we[j]=1 and wa[j]!=0, reg[wa[j]] <= wd[j].
- Writes to address 0 are discarded.
- Write collision (two ports, same address, same cycle): the highest-index port wins, for both storage and bypass.
- Read: rd[i] = 0 if ra[i]==0.
- Read with BYPASS=1 and any we[j] with wa[j]==ra[i]: rd[i] = wd of the highest-index matching port. Otherwise rd[i] = reg[ra[i]].
- Read latency is 0 cycles: combinational, no read-side registers.
- Scoreboard at posedge clk:
  - A write with we[j] and wa[j]!=0 clears busy[wa[j]].
  - alloc_en with alloc_addr!=0 sets busy[alloc_addr].
  - Alloc and write to the same address in the same cycle: alloc wins, so busy ends at 1 (new producer supersedes the completing one).
  - alloc_addr=0 is ignored.
  - Alloc of an already-busy register keeps it at 1. No counting; a single outstanding producer per register is the pipeline's contract.
- rd_busy[i] is combinational:
  - BYPASS=1: busy[ra[i]] & ~(any we[j] with wa[j]==ra[i]).
  - BYPASS=0: busy[ra[i]].
  - Forced 0 when ra[i]==0.
  - Same-cycle alloc does not affect rd_busy; the hazard unit handles its own issue slot.
- Reset mid-operation: pending allocs and in-flight writes are lost. The next cycle after release sees all-zero state.
- No X propagation: for out-of-range addresses (NREGS not power of two is illegal), read returns 0.

Decomposition:
- Shared package/header regfile_pkg: default XLEN, NREGS, AW and the REG_ZERO address constant. The hazard unit and decode stage import the same values.
- One sub-module, regfile_scoreboard, holds the busy vector and the alloc/clear priority logic. The rd_busy derivation stays in the top level.
- The storage array, write priority mux and bypass mux stay in regfile_mp.

Test Plan:
- Reset: hold rst_n=0 and drive we=1, wa=5, wd=32'hDEADBEEF -> rd=0 for ra=5 and busy=0. Release, then read ra=5 -> 0.
- Basic write/read, BYPASS=0: write r3=32'h12345678 at cycle n -> rd for ra=3 returns 32'h12345678 from cycle n+1, and the old value in cycle n.
- Bypass, BYPASS=1: in the same cycle drive we=1, wa=7, wd=32'hA5A5A5A5 and ra[0]=7 -> rd[0]=32'hA5A5A5A5 combinationally; stored value matches next cycle.
- Register 0: write x0=32'hFFFFFFFF and alloc x0 -> rd(ra=0)=0, busy[0]=0, rd_busy=0.
- Collision, NWP=2: port0 writes r9=1 and port1 writes r9=2 in the same cycle -> bypass gives 2 and storage holds 2.
- Scoreboard:
  - Alloc r4 -> busy[4]=1 next cycle.
  - Write r4 with ra=4 -> rd_busy=0 that cycle (BYPASS=1) and busy[4]=0 next cycle.
  - Alloc r4 and write r4 in the same cycle -> busy[4] stays 1.
  - Assert rst_n=0 while busy[4]=1 -> busy clears immediately, without waiting for a clock edge.
